// File: rtl/latch_wr_pkg.sv
// Shared types and default timing for the latch bank writer.
package latch_wr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } wr_state_e;

  localparam int unsigned DEF_SETUP_CYC = 32'd1;
  localparam int unsigned DEF_PULSE_CYC = 32'd2;
  localparam int unsigned DEF_HOLD_CYC  = 32'd1;
  localparam int unsigned DEF_MAX_RETRY = 32'd2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/latch_bank_writer_phase_timer.sv
// Loadable down-counter with a zero flag; times every phase of a write.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Count down to zero and stop; a load always wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/latch_bank_writer.sv
// Sequencer driving a gated-D latch bank with setup/pulse/hold timing and readback.
// Optional macro LATCH_RETRY_EN: rewrite on mismatch up to MAX_RETRY times, adds retry_cnt.
module latch_bank_writer
  import latch_wr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] lat_d,
  output logic             lat_e,
  input  logic [WIDTH-1:0] lat_q,
  output logic             busy,
  output logic             done,
  output logic             err
`ifdef LATCH_RETRY_EN
  ,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
`endif
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  wr_state_e        state_r, state_s;
  logic             load_s, zero_s, accept_s, mismatch_s;
  logic [CW-1:0]    load_val_s;
  logic             done_s, err_s, retry_s;
  logic [WIDTH-1:0] lat_d_r;
  logic             lat_e_r, busy_r, done_r, err_r, in_ready_r;
`ifdef LATCH_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0]    retry_cnt_r;
`endif

  assign accept_s   = in_valid & in_ready_r;
  assign mismatch_s = (lat_q != lat_d_r);

  phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_val (load_val_s),
    .zero     (zero_s)
  );

  // Next-state logic; the readback verdict is formed on the edge entering CHECK.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    err_s   = 1'b0;
    retry_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = SETUP;
        else          state_s = IDLE;
      end
      SETUP: begin
        if (zero_s) state_s = PULSE;
        else        state_s = SETUP;
      end
      PULSE: begin
        if (zero_s) state_s = HOLD;
        else        state_s = PULSE;
      end
      HOLD: begin
        if (zero_s) begin
          state_s = CHECK;
`ifdef LATCH_RETRY_EN
          if (mismatch_s && (retry_cnt_r < RW'(MAX_RETRY))) begin
            done_s = 1'b0;
            err_s  = 1'b0;
          end else begin
            done_s = 1'b1;
            err_s  = mismatch_s;
          end
`else
          done_s = 1'b1;
          err_s  = mismatch_s;
`endif
        end else begin
          state_s = HOLD;
        end
      end
      CHECK: begin
        // A CHECK without done means a retry was granted.
        if (!done_r) begin
          state_s = SETUP;
          retry_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Reload the phase timer on every state entry.
  always_comb begin
    load_s = (state_s != state_r);
    case (state_s)
      SETUP:   load_val_s = CW'(SETUP_CYC - 1);
      PULSE:   load_val_s = CW'(PULSE_CYC - 1);
      HOLD:    load_val_s = CW'(HOLD_CYC - 1);
      default: load_val_s = {CW{1'b0}};
    endcase
  end

  // State and registered outputs, all decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lat_d_r    <= {WIDTH{1'b0}};
      lat_e_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      lat_e_r    <= (state_s == PULSE);
      busy_r     <= (state_s != IDLE);
      in_ready_r <= (state_s == IDLE);
      done_r     <= done_s;
      err_r      <= err_s;
      if (accept_s) lat_d_r <= in_data;
      else          lat_d_r <= lat_d_r;
    end
  end

`ifdef LATCH_RETRY_EN
  // Retries used by the current write; cleared when a new word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          retry_cnt_r <= {RW{1'b0}};
    else if (accept_s) retry_cnt_r <= {RW{1'b0}};
    else if (retry_s)  retry_cnt_r <= retry_cnt_r + {{(RW-1){1'b0}}, 1'b1};
    else               retry_cnt_r <= retry_cnt_r;
  end

  assign retry_cnt = retry_cnt_r;
`endif

  assign in_ready = in_ready_r;
  assign lat_d    = lat_d_r;
  assign lat_e    = lat_e_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Directed bench for latch_bank_writer with a clocked latch-bank model (optional stuck bits).
module tb_latch_bank_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, lat_e, busy, done, err;
  logic [7:0] in_data, lat_d, stuck;
  logic [7:0] lat_q = 8'h00;
  logic       in_valid2, in_ready2, lat_e2, busy2, done2, err2;
  logic [7:0] in_data2, lat_d2;
  logic [7:0] lat_q2 = 8'h00;
`ifdef LATCH_RETRY_EN
  logic [1:0] retry_cnt, retry_cnt2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  latch_bank_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lat_d(lat_d), .lat_e(lat_e), .lat_q(lat_q), .busy(busy), .done(done), .err(err)
`ifdef LATCH_RETRY_EN
    , .retry_cnt(retry_cnt)
`endif
  );

  latch_bank_writer #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2), .MAX_RETRY(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .lat_d(lat_d2), .lat_e(lat_e2), .lat_q(lat_q2), .busy(busy2), .done(done2), .err(err2)
`ifdef LATCH_RETRY_EN
    , .retry_cnt(retry_cnt2)
`endif
  );

  // Latch bank models: transparent while E is high, stuck bits read as 0.
  always @(posedge clk) begin
    if (lat_e)  lat_q  <= lat_d & ~stuck;
    if (lat_e2) lat_q2 <= lat_d2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one write on dut from a cycle where in_ready=1 and trace it until done.
  task automatic do_write(input logic [7:0] data, output int t_d, output int t_e, output int n_high,
                          output int n_rise, output int t_done, output logic err_v, output int rcnt);
    logic prev_e;
    in_data = data; in_valid = 1'b1;
    t_d = -1; t_e = -1; n_high = 0; n_rise = 0; t_done = -1; err_v = 1'b0; rcnt = 0;
    prev_e = 1'b0;
    for (int c = 1; c <= 40 && t_done < 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (lat_d == data && t_d < 0) t_d = c;
      if (lat_e) begin
        n_high++;
        if (t_e < 0) t_e = c;
        if (!prev_e) n_rise++;
      end
      prev_e = lat_e;
      if (done) begin
        t_done = c;
        err_v  = err;
`ifdef LATCH_RETRY_EN
        rcnt = int'(retry_cnt);
`endif
      end
    end
  endtask

  initial begin
    int t_d, t_e, n_high, n_rise, t_done, rcnt, n_low, n_done, bad;
    logic err_v, prev_rdy;
    logic [7:0] prev_d, q_first;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; stuck = 8'h00;
    in_valid2 = 1'b0; in_data2 = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_lat_e", 32'(lat_e), 32'd0);
    chk("rst_lat_d", 32'(lat_d), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(in_ready), 32'd1);

    // Write 0xA5 into a healthy bank.
    do_write(8'hA5, t_d, t_e, n_high, n_rise, t_done, err_v, rcnt);
    chk("a5_lat_d_cycle", 32'(t_d), 32'd1);
    chk("a5_lat_e_first", 32'(t_e), 32'd2);
    chk("a5_lat_e_width", 32'(n_high), 32'd2);
    chk("a5_done_cycle", 32'(t_done), 32'd5);
    chk("a5_err", 32'(err_v), 32'd0);
    chk("a5_q", 32'(lat_q), 32'hA5);
    @(negedge clk);
    chk("a5_ready_next", 32'(in_ready), 32'd1);
    chk("a5_done_pulse", 32'(done), 32'd0);

    // Bit 3 stuck at 0, write 0xFF.
    stuck = 8'h08;
    do_write(8'hFF, t_d, t_e, n_high, n_rise, t_done, err_v, rcnt);
`ifdef LATCH_RETRY_EN
    chk("stuck_done_cycle", 32'(t_done), 32'd15);
    chk("stuck_pulses", 32'(n_rise), 32'd3);
    chk("stuck_retry_cnt", 32'(rcnt), 32'd2);
`else
    chk("stuck_done_cycle", 32'(t_done), 32'd5);
    chk("stuck_pulses", 32'(n_rise), 32'd1);
`endif
    chk("stuck_err", 32'(err_v), 32'd1);
    @(negedge clk);
    stuck = 8'h00;
    chk("stuck_ready_next", 32'(in_ready), 32'd1);

    // Back-to-back 0x01 then 0x02 with in_valid held high.
    in_data = 8'h01; in_valid = 1'b1;
    n_low = -1; n_done = 0; bad = 0; prev_d = lat_d; prev_rdy = 1'b0; q_first = 8'h00;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("b2b_first_word", 32'(lat_d), 32'h01);
        in_data = 8'h02;
      end
      if (prev_rdy) begin
        in_valid = 1'b0;
        chk("b2b_second_word", 32'(lat_d), 32'h02);
      end
      if (in_ready && n_low < 0) n_low = c - 1;
      prev_rdy = in_ready && (n_done == 1) && in_valid;
      if (lat_e && lat_d != prev_d) bad++;
      prev_d = lat_d;
      if (done) begin
        n_done++;
        if (n_done == 1) q_first = lat_q;
      end
    end
    chk("b2b_ready_low", 32'(n_low), 32'd5);
    chk("b2b_done_count", 32'(n_done), 32'd2);
    chk("b2b_q_first", 32'(q_first), 32'h01);
    chk("b2b_q_second", 32'(lat_q), 32'h02);
    chk("b2b_d_stable_e", 32'(bad), 32'd0);

    // Reset asserted mid-PULSE between clock edges.
    in_data = 8'h77; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_in_pulse", 32'(lat_e), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_lat_e", 32'(lat_e), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd0);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("mid_rst_no_done", 32'(n_done), 32'd0);
    do_write(8'h3C, t_d, t_e, n_high, n_rise, t_done, err_v, rcnt);
    chk("after_rst_done", 32'(t_done), 32'd5);
    chk("after_rst_err", 32'(err_v), 32'd0);
    chk("after_rst_q", 32'(lat_q), 32'h3C);

    // Timing 3/1/2 on the second instance.
    chk("p312_ready", 32'(in_ready2), 32'd1);
    in_data2 = 8'h5A; in_valid2 = 1'b1;
    t_e = -1; n_high = 0; t_done = -1; err_v = 1'b0;
    for (int c = 1; c <= 40 && t_done < 0; c++) begin
      @(negedge clk);
      in_valid2 = 1'b0;
      if (lat_e2) begin
        n_high++;
        if (t_e < 0) t_e = c;
      end
      if (done2) begin
        t_done = c;
        err_v  = err2;
      end
    end
    chk("p312_lat_e_first", 32'(t_e), 32'd4);
    chk("p312_lat_e_width", 32'(n_high), 32'd1);
    chk("p312_done_cycle", 32'(t_done), 32'd7);
    chk("p312_err", 32'(err_v), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/latch_bank_writer.md
Name: latch_bank_writer

Overview:
- Sequencer directly upstream of a WIDTH-bit bank of gated D latches (D/E inputs, Q/Q_n outputs).
- Accepts a data word over a valid/ready handshake and drives the bank's D and E with a fixed setup / enable-pulse / hold timing.
- Reads back Q, compares it with the written word, and reports done/err.
- Provides the clocked control that level-sensitive latches lack.

Parameters:
- WIDTH, 8: data and latch-bank width.
- SETUP_CYC, 1: cycles lat_d is stable before lat_e rises; must be >=1.
- PULSE_CYC, 2: cycles lat_e is high; must be >=1.
- HOLD_CYC, 1: cycles lat_d is held after lat_e falls; must be >=1.
- MAX_RETRY, 2: rewrite attempts after a mismatch; used only with LATCH_RETRY_EN; must be >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  WIDTH  word to write.
- lat_d  out  WIDTH  drives the latch bank D inputs.
- lat_e  out  1  common enable to the latch bank.
- lat_q  in  WIDTH  latch bank Q outputs, read back.
- busy  out  1  a write is in progress.
- done  out  1  one-cycle pulse when a write completes.
- err  out  1  readback mismatch; valid only while done=1.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, lat_e=0, lat_d=0, busy=0, done=0, err=0, in_ready=0 while rst=1. All outputs are registered, so lat_e drops on rst assertion without waiting for clk.
- States: IDLE, SETUP, PULSE, HOLD, CHECK.
- in_ready is 1 only in IDLE with rst=0. Acceptance occurs on the edge where in_valid & in_ready.
- On acceptance: the word is registered into lat_d and the state moves to SETUP.
  - busy=1 from SETUP through CHECK.
  - in_data is ignored outside IDLE.
- SETUP: lat_e=0 for SETUP_CYC cycles, then PULSE.
- PULSE: lat_e=1 for exactly PULSE_CYC cycles, then HOLD.
- HOLD: lat_e=0, lat_d unchanged for HOLD_CYC cycles, then CHECK.
- CHECK (one cycle):
  - lat_q is sampled and done=1.
  - err = (lat_q != lat_d).
  - Next state is IDLE, so in_ready=1 in the following cycle.
- Latency: done is asserted SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles after the acceptance edge (5 with defaults).
- Back-to-back: the minimum interval between acceptances is that latency + 1.
- lat_d is stable for the entire SETUP..CHECK window. lat_d and lat_e never change on the same edge, except lat_e falling on reset.
- lat_d retains the last written word in IDLE.
- Phase lengths are set by one down-counter wide enough for the largest of SETUP_CYC, PULSE_CYC, HOLD_CYC. The counter is reloaded on every state entry.
- Reset mid-write (any state): the write is aborted, no done pulse is produced, and latch contents are undefined.
- If in_valid drops before acceptance, nothing happens. There is no timeout.

Optional Feature:
- Macro: LATCH_RETRY_EN.
- Defined:
  - On a mismatch in CHECK with retries remaining, done stays 0 and the state returns to SETUP with the same lat_d.
  - After MAX_RETRY failed rewrites, done=1 and err=1.
  - A successful retry gives done=1 and err=0.
  - Adds output retry_cnt (clog2(MAX_RETRY+1) bits). It holds the number of retries used and is valid with done. It resets to 0 and clears on acceptance.
- Undefined:
  - A single attempt; a mismatch gives done=1 and err=1 immediately.
  - No retry_cnt port.

Decomposition:
- Package latch_wr_pkg holds:
  - the state enum typedef (IDLE, SETUP, PULSE, HOLD, CHECK);
  - default timing constants (SETUP_CYC, PULSE_CYC, HOLD_CYC, MAX_RETRY).
- One sub-module, phase_timer: a loadable down-counter with a zero flag, used for every phase.

Test Plan:
- Reset, then write 0xA5 with a correct latch model:
  - lat_e=1 for exactly 2 cycles, starting 1 cycle after lat_d=0xA5.
  - done=1 and err=0 exactly 5 cycles after the acceptance edge.
  - in_ready=1 in the next cycle.
- Latch model with bit 3 stuck at 0, write 0xFF, macro undefined: done=1 and err=1 at the 5th cycle.
- Same stuck-bit model with LATCH_RETRY_EN, MAX_RETRY=2:
  - three lat_e pulses;
  - done=1 after 15 cycles, err=1, retry_cnt=2.
- in_valid held high with 0x01 then 0x02 back-to-back:
  - in_ready low for 5 cycles between acceptances;
  - both words written in order;
  - lat_d never changes while lat_e=1.
- Assert rst mid-PULSE:
  - lat_e=0, busy=0, in_ready=0 immediately, with no clk edge needed;
  - no done pulse;
  - after release, a write of 0x3C completes with err=0.
- Parameters SETUP_CYC=3, PULSE_CYC=1, HOLD_CYC=2: done arrives 7 cycles after acceptance, and lat_e is high for exactly 1 cycle.
